// File: rtl/coalescing_store_buffer_if.sv
`default_nettype none
// ============================================================================
// Module   : coalescing_store_buffer_if
// Brief    : Push, drain, lookup and status bundle for the coalescing store buffer.
// Revision : 1.0 - initial release
// ============================================================================
interface coalescing_store_buffer_if #(
  parameter int NUM_ENTRIES = 8,
  parameter int NUM_THREADS = 2,
  parameter int ADDR_W      = 32,
  parameter int LINE_BYTES  = 16
);
  localparam int OFF_W  = $clog2(LINE_BYTES);
  localparam int TAG_W  = ADDR_W - OFF_W;
  localparam int TID_W  = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1;
  localparam int CNT_W  = $clog2(NUM_ENTRIES + 1);
  localparam int DATA_W = 8 * LINE_BYTES;

  logic                                   push_valid;
  logic                                   push_ready;
  logic [TID_W-1:0]                       push_tid;
  logic [TAG_W-1:0]                       push_tag;
  logic [DATA_W-1:0]                      push_data;
  logic [LINE_BYTES-1:0]                  push_be;

  logic                                   drain_valid;
  logic                                   drain_ready;
  logic [TID_W-1:0]                       drain_tid;
  logic [TAG_W-1:0]                       drain_tag;
  logic [DATA_W-1:0]                      drain_data;
  logic [LINE_BYTES-1:0]                  drain_be;

  logic [NUM_THREADS-1:0][TAG_W-1:0]      lookup_tag;
  logic [NUM_THREADS-1:0]                 lookup_hit;
  logic [NUM_THREADS-1:0][DATA_W-1:0]     lookup_data;
  logic [NUM_THREADS-1:0][LINE_BYTES-1:0] lookup_be;

  logic [CNT_W-1:0]                       count;
  logic                                   empty;
  logic                                   full;

  modport master (
    output push_valid, push_tid, push_tag, push_data, push_be,
    output drain_ready, lookup_tag,
    input  push_ready, drain_valid, drain_tid, drain_tag, drain_data, drain_be,
    input  lookup_hit, lookup_data, lookup_be, count, empty, full
  );

  modport slave (
    input  push_valid, push_tid, push_tag, push_data, push_be,
    input  drain_ready, lookup_tag,
    output push_ready, drain_valid, drain_tid, drain_tag, drain_data, drain_be,
    output lookup_hit, lookup_data, lookup_be, count, empty, full
  );
endinterface
`default_nettype wire

// File: rtl/coalescing_store_buffer.sv
`default_nettype none
// ============================================================================
// Module   : coalescing_store_buffer
// Brief    : Per-thread line store buffer; merges stores, drains in FIFO order.
// Revision : 1.0 - initial release
// ============================================================================
module coalescing_store_buffer #(
  parameter int NUM_ENTRIES = 8,
  parameter int NUM_THREADS = 2,
  parameter int ADDR_W      = 32,
  parameter int LINE_BYTES  = 16
) (
  input  wire logic                clk_i,
  input  wire logic                rst_i,
  coalescing_store_buffer_if.slave bus_io
);
  localparam int OFF_W  = $clog2(LINE_BYTES);
  localparam int TAG_W  = ADDR_W - OFF_W;
  localparam int TID_W  = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1;
  localparam int CNT_W  = $clog2(NUM_ENTRIES + 1);
  localparam int PTR_W  = $clog2(NUM_ENTRIES);
  localparam int DATA_W = 8 * LINE_BYTES;

  logic [NUM_ENTRIES-1:0] valid_q;
  logic [TID_W-1:0]       tid_q  [NUM_ENTRIES];
  logic [TAG_W-1:0]       tag_q  [NUM_ENTRIES];
  logic [DATA_W-1:0]      data_q [NUM_ENTRIES];
  logic [LINE_BYTES-1:0]  be_q   [NUM_ENTRIES];
  logic [PTR_W-1:0]       head_q, head_d;
  logic [PTR_W-1:0]       tail_q, tail_d;
  logic [CNT_W-1:0]       count_q, count_d;

  logic [NUM_ENTRIES-1:0] w_match;
  logic [DATA_W-1:0]      w_push_mask;
  logic                   w_coalesce;
  logic                   w_full;
  logic                   w_empty;
  logic                   w_alloc;
  logic                   w_pop;

  // The head is excluded so drain contents stay stable under backpressure.
  generate
    for (genvar e = 0; e < NUM_ENTRIES; e++) begin : g_match
      assign w_match[e] = valid_q[e] && (PTR_W'(e) != head_q) &&
                          (tid_q[e] == bus_io.push_tid) && (tag_q[e] == bus_io.push_tag);
    end
    for (genvar b = 0; b < LINE_BYTES; b++) begin : g_push_mask
      assign w_push_mask[8*b +: 8] = {8{bus_io.push_be[b]}};
    end
  endgenerate

  assign w_coalesce = bus_io.push_valid && (|w_match);
  assign w_full     = (count_q == CNT_W'(NUM_ENTRIES));
  assign w_empty    = (count_q == '0);
  assign w_alloc    = bus_io.push_valid && !w_coalesce && !w_full;
  assign w_pop      = !w_empty && bus_io.drain_ready;

  assign head_d  = head_q + PTR_W'(w_pop);
  assign tail_d  = tail_q + PTR_W'(w_alloc);
  assign count_d = count_q + CNT_W'(w_alloc) - CNT_W'(w_pop);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int e = 0; e < NUM_ENTRIES; e++) begin
        tid_q[e]  <= '0;
        tag_q[e]  <= '0;
        data_q[e] <= '0;
        be_q[e]   <= '0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      if (w_pop) begin
        valid_q[head_q] <= 1'b0;
      end
      if (w_alloc) begin
        valid_q[tail_q] <= 1'b1;
        tid_q[tail_q]   <= bus_io.push_tid;
        tag_q[tail_q]   <= bus_io.push_tag;
        data_q[tail_q]  <= bus_io.push_data & w_push_mask;
        be_q[tail_q]    <= bus_io.push_be;
      end
      for (int e = 0; e < NUM_ENTRIES; e++) begin
        if (w_coalesce && w_match[e]) begin
          data_q[e] <= (data_q[e] & ~w_push_mask) | (bus_io.push_data & w_push_mask);
          be_q[e]   <= be_q[e] | bus_io.push_be;
        end
      end
    end
  end

  assign bus_io.push_ready  = w_coalesce || !w_full;
  assign bus_io.drain_valid = !w_empty;
  assign bus_io.drain_tid   = w_empty ? '0 : tid_q[head_q];
  assign bus_io.drain_tag   = w_empty ? '0 : tag_q[head_q];
  assign bus_io.drain_data  = w_empty ? '0 : data_q[head_q];
  assign bus_io.drain_be    = w_empty ? '0 : be_q[head_q];
  assign bus_io.count       = count_q;
  assign bus_io.empty       = w_empty;
  assign bus_io.full        = w_full;

  // At most a head entry and one younger entry can share a (tid, tag); the younger wins.
  generate
    for (genvar t = 0; t < NUM_THREADS; t++) begin : g_lookup
      logic [NUM_ENTRIES-1:0] w_lk_match;
      logic [DATA_W-1:0]      w_young_data;
      logic [DATA_W-1:0]      w_young_mask;
      logic [LINE_BYTES-1:0]  w_young_be;
      logic                   w_head_hit;

      for (genvar e = 0; e < NUM_ENTRIES; e++) begin : g_cmp
        assign w_lk_match[e] = valid_q[e] && (tid_q[e] == TID_W'(t)) &&
                               (tag_q[e] == bus_io.lookup_tag[t]);
      end

      always_comb begin
        w_young_data = '0;
        w_young_be   = '0;
        for (int e = 0; e < NUM_ENTRIES; e++) begin
          if (w_lk_match[e] && (PTR_W'(e) != head_q)) begin
            w_young_data = w_young_data | data_q[e];
            w_young_be   = w_young_be | be_q[e];
          end
        end
      end

      for (genvar b = 0; b < LINE_BYTES; b++) begin : g_young_mask
        assign w_young_mask[8*b +: 8] = {8{w_young_be[b]}};
      end

      assign w_head_hit            = w_lk_match[head_q];
      assign bus_io.lookup_hit[t]  = |w_lk_match;
      assign bus_io.lookup_data[t] = (w_head_hit ? (data_q[head_q] & ~w_young_mask) : '0) |
                                     w_young_data;
      assign bus_io.lookup_be[t]   = (w_head_hit ? be_q[head_q] : '0) | w_young_be;
    end
  endgenerate
endmodule
`default_nettype wire
